// File: rtl/diff_avg.sv
// Block-averaging decimator: sums 2^LOG2_N samples captured on i_dval rising edges
// and presents the rounded mean on a valid/ready port, counting results lost to back-pressure.
module diff_avg #(
   parameter int unsigned DATA_W = 20,
   parameter int unsigned LOG2_N = 3,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_dval,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam int unsigned SUM_W = DATA_W + LOG2_N;
   localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (LOG2_N - 1);

   logic              r_dval;
   logic [SUM_W-1:0]  r_acc;
   logic [LOG2_N-1:0] r_cnt;
   logic [SUM_W-1:0]  r_fin;
   logic              r_done;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic [CNT_W-1:0]  r_drop;

   logic              w_capture;
   logic [SUM_W-1:0]  w_sample;
   logic [SUM_W-1:0]  w_rnd_sum;
   logic [DATA_W-1:0] w_mean;
   logic [SUM_W-1:0]  w_acc_d;
   logic [LOG2_N-1:0] w_cnt_d;
   logic [SUM_W-1:0]  w_fin_d;
   logic              w_done_d;
   logic [DATA_W-1:0] w_data_d;
   logic              w_valid_d;
   logic [CNT_W-1:0]  w_drop_d;

   assign w_capture = i_dval & ~r_dval;
   assign w_sample  = SUM_W'(i_data);
   assign w_rnd_sum = r_fin + RND;
   assign w_mean    = DATA_W'(w_rnd_sum >> LOG2_N);

   // Accumulator; a capture coincident with clr is dropped, not deferred.
   always_comb begin
      w_acc_d  = r_acc;
      w_cnt_d  = r_cnt;
      w_fin_d  = r_fin;
      w_done_d = 1'b0;
      if (clr) begin
         w_acc_d = '0;
         w_cnt_d = '0;
      end else if (w_capture) begin
         if (&r_cnt) begin
            w_fin_d  = r_acc + w_sample;
            w_done_d = 1'b1;
            w_acc_d  = '0;
            w_cnt_d  = '0;
         end else begin
            w_acc_d = r_acc + w_sample;
            w_cnt_d = r_cnt + LOG2_N'(1);
         end
      end
   end

   // A new result may replace one being accepted in the same cycle.
   always_comb begin
      w_data_d  = r_data;
      w_valid_d = r_valid;
      w_drop_d  = r_drop;
      if (clr) begin
         w_valid_d = 1'b0;
         w_drop_d  = '0;
      end else if (r_done) begin
         if (!r_valid || o_ready) begin
            w_data_d  = w_mean;
            w_valid_d = 1'b1;
         end else if (r_drop != {CNT_W{1'b1}}) begin
            w_drop_d = r_drop + CNT_W'(1);
         end
      end else if (r_valid && o_ready) begin
         w_valid_d = 1'b0;
      end
   end

   // r_dval resets high so a level held through reset is not taken as an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dval  <= 1'b1;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_fin   <= '0;
         r_done  <= 1'b0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_dval  <= i_dval;
         r_acc   <= w_acc_d;
         r_cnt   <= w_cnt_d;
         r_fin   <= w_fin_d;
         r_done  <= w_done_d;
         r_data  <= w_data_d;
         r_valid <= w_valid_d;
         r_drop  <= w_drop_d;
      end
   end

   assign o_data     = r_data;
   assign o_valid    = r_valid;
   assign o_drop_cnt = r_drop;

endmodule

// File: doc/diff_avg.md
# diff_avg

Block-averaging decimator downstream of the TDC differencing stage. Captures one 20-bit difference sample per rising edge of the upstream valid level, sums 2^LOG2_N consecutive samples, and emits the rounded mean. Results go out over a valid/ready handshake to the packetiser/readout logic. Results that cannot be delivered under back-pressure are dropped and counted.

## Interface
- DATA_W, 20, sample and result width (unsigned).
- LOG2_N, 3, log2 of block length N; legal range 1..8.
- CNT_W, 8, width of drop counter.

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous restart: clears accumulator, sample count, output stage and drop counter.
- i_data  in  DATA_W  sample from differencing stage; stable while i_dval high.
- i_dval  in  1  upstream valid level; a sample is taken only on its 0→1 transition.
- o_data  out  DATA_W  averaged result.
- o_valid  out  1  result present; held until accepted.
- o_ready  in  1  downstream accept.
- o_drop_cnt  out  CNT_W  saturating count of results lost to back-pressure.

## Operation
- Edge detect:
  - dval_q <= i_dval each cycle.
  - Capture when i_dval & !dval_q.
  - dval_q resets to 1, so an i_dval held high through reset release produces no capture until it falls and rises again.
- Accumulate:
  - acc is unsigned, DATA_W+LOG2_N bits; cnt is LOG2_N bits.
  - On capture with cnt != N-1: acc += i_data, cnt++.
- Block complete, on capture with cnt == N-1:
  - fin <= acc + i_data.
  - done <= 1.
  - acc <= 0, cnt <= 0.
  - done is a one-cycle pulse.
- Result: mean = (fin + 2^(LOG2_N-1)) >> LOG2_N, truncated to DATA_W.
  - The maximum sum plus the rounding term is < 2^(DATA_W+LOG2_N), and the mean is ≤ 2^DATA_W-1.
  - Neither the sum nor the mean can overflow; no saturation logic.
- Output stage, evaluated on a done cycle:
  - If !o_valid, or o_valid & o_ready: o_data <= mean, o_valid <= 1.
  - Else: result discarded, o_data unchanged, o_drop_cnt += 1, saturating at 2^CNT_W-1.
- Without done: o_valid & o_ready → o_valid <= 0. o_data is not cleared.
- clr:
  - Priority over everything.
  - acc, cnt, done, o_valid, o_drop_cnt <= 0.
  - A capture edge in the clr cycle is discarded.
  - dval_q still updates, so the edge is consumed, not deferred.
- Reset values: o_data 0, o_valid 0, o_drop_cnt 0; internal acc 0, cnt 0, fin 0, done 0, dval_q 1.
- Reset asserted mid-block discards the partial sum. After release, accumulation restarts at cnt 0.

## Timing
- Capture: the rising edge of i_dval is seen at clock edge k. acc/cnt update at k; for the N-th sample, fin/done update at k.
- Result latency: o_data/o_valid update at edge k+1, visible from cycle k+1. Latency is 2 clocks from i_dval rising to o_valid.
- Handshake: transfer occurs on any edge where o_valid & o_ready. o_data is stable and o_valid stays high until then.
- A done in the same cycle as a transfer loads the new result. o_valid stays 1 and no drop is counted.
- Throughput: one capture per i_dval rising edge. Edges may be as close as 2 cycles apart (high 1, low 1). No dead cycles at block boundaries.
- o_drop_cnt increments at the same edge where the drop occurs.

## Test plan
- Reset and stray edge:
  - Stimulus: assert rst with i_dval=1, release, hold i_dval=1 for 20 cycles.
  - Required: o_valid=0, o_drop_cnt=0, no capture. A subsequent 0→1 is captured as sample 1.
- Basic mean (LOG2_N=3, o_ready=1):
  - Stimulus: 8 edges, i_data=30000 each.
  - Required: o_valid high for exactly 1 cycle, 2 clocks after the 8th edge, with o_data=30000.
- Rounding:
  - Stimulus: samples 0×7 then 4.
  - Required: o_data=1 ((4+4)>>3). Samples 0×7 then 3 give o_data=0.
  - Stimulus: 8×0xFFFFF.
  - Required: o_data=0xFFFFF.
- Back-pressure:
  - Stimulus: o_ready=0, 16 edges of 500 then 600.
  - Required: o_data=500 held, o_valid=1, o_drop_cnt=1.
  - Stimulus: raise o_ready.
  - Required: o_valid falls the next cycle.
  - Stimulus: 300 more dropped blocks.
  - Required: o_drop_cnt=255.
- Simultaneous accept and done:
  - Stimulus: o_ready pulsed high exactly on the cycle the next done fires.
  - Required: new o_data loaded, o_valid stays 1, o_drop_cnt unchanged.
- clr mid-block:
  - Stimulus: 5 edges of 9999, clr for 1 cycle coincident with a 6th edge, then 8 edges of 100.
  - Required: the only result is o_data=100; o_drop_cnt=0.
